// File: rtl/matmul_pkg.sv
// Shared address map, register bit positions and engine state type for the
// Wishbone matrix multiply accelerator.
package matmul_pkg;

  // Word addresses of the register file and matrix windows.
  localparam logic [31:0] CTRL_ADR   = 32'h0000_0000;
  localparam logic [31:0] STATUS_ADR = 32'h0000_0001;
  localparam logic [31:0] A_BASE     = 32'h0000_0040;
  localparam logic [31:0] B_BASE     = 32'h0000_0080;
  localparam logic [31:0] C_BASE     = 32'h0000_00C0;

  // CTRL bit positions.
  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_SIGNED = 2;

  // STATUS bit positions.
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE,
    FIN
  } eng_state_t;

  // Index width that stays at least one bit wide when the range has one entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/matmul_seq_engine.sv
// Sequential matrix multiply engine: one multiply-accumulate per clock,
// walking C row by row and writing each finished element into C storage.
module matmul_seq_engine
  import matmul_pkg::*;
#(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(N) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_mode,
  input  logic [N*N*DW-1:0]   a_flat,
  input  logic [N*N*DW-1:0]   b_flat,
  output logic [N*N*ACCW-1:0] c_flat,
  output logic                busy,
  output logic                fin
);

  localparam int CW = idx_width(N);
  localparam int IW = idx_width(N*N);

  eng_state_t             state;
  logic [CW-1:0]          i;
  logic [CW-1:0]          j;
  logic [CW-1:0]          k;
  logic [ACCW-1:0]        acc;
  logic                   mode;
  logic [IW-1:0]          a_idx;
  logic [IW-1:0]          b_idx;
  logic [IW-1:0]          c_idx;
  logic [DW-1:0]          a_elem;
  logic [DW-1:0]          b_elem;
  logic signed [DW:0]     a_op;
  logic signed [DW:0]     b_op;
  logic signed [2*DW+1:0] prod;

  assign a_idx  = IW'(i * N + k);
  assign b_idx  = IW'(k * N + j);
  assign c_idx  = IW'(i * N + j);
  assign a_elem = a_flat[a_idx*DW +: DW];
  assign b_elem = b_flat[b_idx*DW +: DW];

  // One extra operand bit carries either the sign or a zero, so a single
  // signed multiplier serves both modes.
  assign a_op = {mode & a_elem[DW-1], a_elem};
  assign b_op = {mode & b_elem[DW-1], b_elem};
  assign prod = a_op * b_op;

  // Walk (i,j) over C, accumulate over k, store the element, then flag completion.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      i      <= '0;
      j      <= '0;
      k      <= '0;
      acc    <= '0;
      mode   <= 1'b0;
      busy   <= 1'b0;
      fin    <= 1'b0;
      // NOTE: C storage is reset too, so an aborted run leaves no partial results readable.
      c_flat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            acc   <= '0;
            mode  <= signed_mode;
            busy  <= 1'b1;
          end
        end
        MAC: begin
          acc <= acc + ACCW'(prod);
          if (k == CW'(N-1)) begin
            k     <= '0;
            state <= STORE;
          end else begin
            k <= k + 1'b1;
          end
        end
        STORE: begin
          c_flat[c_idx*ACCW +: ACCW] <= acc;
          acc <= '0;
          if (j == CW'(N-1)) begin
            j <= '0;
            if (i == CW'(N-1)) begin
              i     <= '0;
              state <= FIN;
              fin   <= 1'b1;
            end else begin
              i     <= i + 1'b1;
              state <= MAC;
            end
          end else begin
            j     <= j + 1'b1;
            state <= MAC;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          fin   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/wb_matmul_accel.sv
// Wishbone-classic slave around the matrix multiply engine: address decode,
// A/B operand storage, CTRL/STATUS registers, registered read data and irq.
module wb_matmul_accel
  import matmul_pkg::*;
#(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 2*DW + $clog2(N) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat_mosi,
  output logic [31:0] dat_miso,
  output logic        ack,
  output logic        err,
  output logic        irq
);

  localparam int          IW   = idx_width(N*N);
  localparam logic [31:0] NN_W = 32'(N*N);

  logic [N*N*DW-1:0]   a_flat;
  logic [N*N*DW-1:0]   b_flat;
  logic [N*N*ACCW-1:0] c_flat;
  logic                ctrl_irq_en;
  logic                ctrl_signed;
  logic                done;
  logic                busy;
  logic                eng_fin;

  logic                req;
  logic                bad;
  logic                wr_ok;
  logic                start;
  logic                in_ctrl;
  logic                in_status;
  logic                in_a;
  logic                in_b;
  logic                in_c;
  logic [31:0]         rdata;
  logic [IW-1:0]       a_idx;
  logic [IW-1:0]       b_idx;
  logic [IW-1:0]       c_idx;
  logic                unused_bits;

  assign a_idx       = IW'(adr - A_BASE);
  assign b_idx       = IW'(adr - B_BASE);
  assign c_idx       = IW'(adr - C_BASE);
  assign irq         = done & ctrl_irq_en;
  assign unused_bits = ^{sel[3:1], dat_mosi[31:DW]};

  // Extend a stored element of width w to a 32-bit bus word.
  function automatic logic [31:0] ext32(input logic [ACCW-1:0] v, input int w,
                                        input logic sgn);
    logic [63:0] wide;
    wide = 64'(v);
    for (int b = 0; b < 64; b++) begin
      if (b >= w && sgn && v[w-1]) wide[b] = 1'b1;
    end
    return wide[31:0];
  endfunction

  // Decode the current request: region hit, error classification and read data.
  // NOTE: every signal gets a default first so no path through the block infers a latch.
  always_comb begin
    req       = cyc & stb & ~ack & ~err;
    in_ctrl   = (adr == CTRL_ADR);
    in_status = (adr == STATUS_ADR);
    in_a      = (adr >= A_BASE) && (adr < A_BASE + NN_W);
    in_b      = (adr >= B_BASE) && (adr < B_BASE + NN_W);
    in_c      = (adr >= C_BASE) && (adr < C_BASE + NN_W);
    bad       = ~(in_ctrl | in_status | in_a | in_b | in_c)
              | (we & in_c)
              | (we & busy & (in_ctrl | in_a | in_b))
              | (~we & busy & in_c);
    wr_ok     = req & ~bad & we;
    start     = wr_ok & in_ctrl & sel[0] & dat_mosi[CTRL_START];
    rdata     = '0;
    if (in_ctrl) begin
      rdata[CTRL_IRQ_EN] = ctrl_irq_en;
      rdata[CTRL_SIGNED] = ctrl_signed;
    end else if (in_status) begin
      rdata[STATUS_BUSY] = busy;
      rdata[STATUS_DONE] = done;
    end else if (in_a) begin
      rdata = ext32(ACCW'(a_flat[a_idx*DW +: DW]), DW, ctrl_signed);
    end else if (in_b) begin
      rdata = ext32(ACCW'(b_flat[b_idx*DW +: DW]), DW, ctrl_signed);
    end else if (in_c) begin
      rdata = ext32(c_flat[c_idx*ACCW +: ACCW], ACCW, ctrl_signed);
    end
  end

  // Bus response, register writes and the sticky DONE flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_miso    <= '0;
      ack         <= 1'b0;
      err         <= 1'b0;
      a_flat      <= '0;
      b_flat      <= '0;
      ctrl_irq_en <= 1'b0;
      ctrl_signed <= 1'b0;
      done        <= 1'b0;
    end else begin
      ack <= req & ~bad;
      err <= req & bad;
      if (req) dat_miso <= (~bad & ~we) ? rdata : 32'h0;
      if (wr_ok && in_ctrl && sel[0]) begin
        ctrl_irq_en <= dat_mosi[CTRL_IRQ_EN];
        ctrl_signed <= dat_mosi[CTRL_SIGNED];
      end
      if (wr_ok && in_a && sel[0]) a_flat[a_idx*DW +: DW] <= dat_mosi[DW-1:0];
      if (wr_ok && in_b && sel[0]) b_flat[b_idx*DW +: DW] <= dat_mosi[DW-1:0];
      // Completion outranks a same-cycle write-1-to-clear.
      if (eng_fin) begin
        done <= 1'b1;
      end else if (start) begin
        done <= 1'b0;
      end else if (wr_ok && in_status && sel[0] && dat_mosi[STATUS_DONE]) begin
        done <= 1'b0;
      end
    end
  end

  matmul_seq_engine #(
    .N    (N),
    .DW   (DW),
    .ACCW (ACCW)
  ) u_engine (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .signed_mode (dat_mosi[CTRL_SIGNED]),
    .a_flat      (a_flat),
    .b_flat      (b_flat),
    .c_flat      (c_flat),
    .busy        (busy),
    .fin         (eng_fin)
  );

endmodule
